// File: rtl/pc_branch_ctrl_pkg.sv
// Shared definitions for the PC / branch control block: branch funct3
// encodings, FSM state encoding, the default reset vector, and the
// branch-condition decode helper.
package pc_branch_ctrl_pkg;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

   // Branch condition encodings carried in funct3.
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_TRAP  = 2'd2
   } state_t;

   // Decide whether a conditional branch is taken from the comparator flags.
   // Signed and unsigned variants share the same flag; the comparator mode is
   // chosen separately through funct3[1]. Reserved encodings never branch.
   function automatic logic branch_cond(input logic [2:0] funct3,
                                        input logic       eq,
                                        input logic       lt);
      logic cond;
      cond = 1'b0;
      case (funct3)
         F3_BEQ:           cond = eq;
         F3_BNE:           cond = !eq;
         F3_BLT, F3_BLTU:  cond = lt;
         F3_BGE, F3_BGEU:  cond = !lt;
         default:          cond = 1'b0;
      endcase
      return cond;
   endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Combinational redirect decision and target address generation for the
// current instruction. JALR wins over JAL, which wins over a branch.
module branch_target_gen
   import pc_branch_ctrl_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [2:0]  funct3,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        br_eq,
   input  logic        br_lt,
   output logic        redirect,
   output logic [31:0] target,
   output logic        misaligned
);

   logic [31:0] pc_rel;
   logic [31:0] jalr_sum;

   // Both additions wrap modulo 2^32; there is deliberately no carry out.
   assign pc_rel   = pc + imm;
   assign jalr_sum = rs1_data + imm;

   // Select the redirect target by class priority and decide whether it is taken.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      redirect = 1'b0;
      target   = pc_rel;
      if (is_jalr) begin
         redirect = 1'b1;
         target   = {jalr_sum[31:1], 1'b0};
      end else if (is_jal) begin
         redirect = 1'b1;
         target   = pc_rel;
      end else if (is_branch) begin
         redirect = branch_cond(funct3, br_eq, br_lt);
         target   = pc_rel;
      end
   end

   // Only a redirect can land off a word boundary; sequential flow never does.
   assign misaligned = redirect & (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter and control-flow sequencer. A three-state FSM boots, then
// fetches one instruction per ready cycle, redirecting on taken branches and
// jumps, and freezes in a sticky trap on a misaligned target.
module pc_branch_ctrl
   import pc_branch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        imem_ready,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [2:0]  funct3,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        br_eq,
   input  logic        br_lt,
   output logic        br_un,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_req,
   output logic        retire,
   output logic        taken,
   output logic        trap,
   output logic [15:0] taken_cnt
);

   state_t      state;
   logic        redirect;
   logic [31:0] target;
   logic        misaligned;
   logic [31:0] next_pc;

   branch_target_gen u_target_gen (
      .pc         (pc),
      .is_branch  (is_branch),
      .is_jal     (is_jal),
      .is_jalr    (is_jalr),
      .funct3     (funct3),
      .imm        (imm),
      .rs1_data   (rs1_data),
      .br_eq      (br_eq),
      .br_lt      (br_lt),
      .redirect   (redirect),
      .target     (target),
      .misaligned (misaligned)
   );

   // Unsigned variants (BLTU/BGEU) are the encodings with funct3[1] set.
   assign br_un    = funct3[1];
   assign pc_plus4 = pc + 32'd4;
   assign next_pc  = redirect ? target : pc_plus4;

   // Completion is combinational so the instruction retires in its ready cycle.
   assign retire = (state == ST_FETCH) & imem_ready & !misaligned;
   assign taken  = retire & redirect;

   // FSM with its registered outputs, plus the PC and redirect counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state     <= ST_BOOT;
         pc        <= RESET_VECTOR;
         taken_cnt <= 16'd0;
         fetch_req <= 1'b0;
         trap      <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state     <= ST_FETCH;
               fetch_req <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ready) begin
                  if (misaligned) begin
                     // PC keeps the faulting instruction's address.
                     state     <= ST_TRAP;
                     fetch_req <= 1'b0;
                     trap      <= 1'b1;
                  end else begin
                     pc <= next_pc;
                     if (redirect) begin
                        taken_cnt <= taken_cnt + 16'd1;
                     end
                  end
               end
            end
            ST_TRAP: begin
               fetch_req <= 1'b0;
               trap      <= 1'b1;
            end
            default: begin
               state     <= ST_BOOT;
               fetch_req <= 1'b0;
               trap      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed testbench for pc_branch_ctrl with hand-computed expectations.
module tb_pc_branch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        imem_ready;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic [2:0]  funct3;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        br_eq;
   logic        br_lt;
   logic        br_un;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_req;
   logic        retire;
   logic        taken;
   logic        trap;
   logic [15:0] taken_cnt;

   int tests;
   int failed;

   pc_branch_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_ready (imem_ready),
      .is_branch  (is_branch),
      .is_jal     (is_jal),
      .is_jalr    (is_jalr),
      .funct3     (funct3),
      .imm        (imm),
      .rs1_data   (rs1_data),
      .br_eq      (br_eq),
      .br_lt      (br_lt),
      .br_un      (br_un),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .fetch_req  (fetch_req),
      .retire     (retire),
      .taken      (taken),
      .trap       (trap),
      .taken_cnt  (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      funct3    = 3'b000;
      imm       = 32'd0;
      rs1_data  = 32'd0;
      br_eq     = 1'b0;
      br_lt     = 1'b0;
   endtask

   // Reset, release, and step through BOOT so the DUT sits in FETCH at pc=0.
   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      imem_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      imem_ready = 1'b1;
      tick();
      tick();
      #1;
      tests++; if (pc !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
      tests++; if (fetch_req !== 1'b0) begin failed++; $display("FAIL reset_fetch_req: got %b expected 0", fetch_req); end
      tests++; if (retire !== 1'b0 || taken !== 1'b0) begin failed++; $display("FAIL reset_retire_taken: got %b%b expected 00", retire, taken); end
      tests++; if (trap !== 1'b0) begin failed++; $display("FAIL reset_trap: got %b expected 0", trap); end
      tests++; if (taken_cnt !== 16'h0) begin failed++; $display("FAIL reset_cnt: got %h expected 0000", taken_cnt); end
      rst_n = 1'b1;
      #1;
      tests++; if (fetch_req !== 1'b0 || retire !== 1'b0 || pc !== 32'h0) begin failed++; $display("FAIL boot_cycle: fetch_req=%b retire=%b pc=%h expected 0 0 00000000", fetch_req, retire, pc); end
      tick();
      tests++; if (fetch_req !== 1'b1 || retire !== 1'b1 || pc !== 32'h0) begin failed++; $display("FAIL first_fetch: fetch_req=%b retire=%b pc=%h expected 1 1 00000000", fetch_req, retire, pc); end
      tick();
      tests++; if (pc !== 32'h4) begin failed++; $display("FAIL seq_pc4: got %h expected 00000004", pc); end
      tick();
      tests++; if (pc !== 32'h8 || pc_plus4 !== 32'hC) begin failed++; $display("FAIL seq_pc8: pc=%h pc_plus4=%h expected 00000008 0000000c", pc, pc_plus4); end
      tests++; if (taken_cnt !== 16'h0) begin failed++; $display("FAIL seq_cnt: got %h expected 0000", taken_cnt); end
   endtask

   task automatic test_branch();
      logic [2:0]  t_f3   [8] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b111, 3'b010, 3'b011};
      logic        t_eq   [8] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
      logic        t_lt   [8] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
      logic        t_tk   [8] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
      logic        t_un   [8] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
      logic [31:0] exp_pc;
      // Jump from pc=8 to 0x100.
      is_jal = 1'b1;
      imm    = 32'h0000_00F8;
      #1;
      tests++; if (taken !== 1'b1) begin failed++; $display("FAIL jal_taken: got %b expected 1", taken); end
      tick();
      clear_inputs();
      tests++; if (pc !== 32'h100 || taken_cnt !== 16'd1) begin failed++; $display("FAIL jal_pc: pc=%h cnt=%0d expected 00000100 1", pc, taken_cnt); end
      // BLTU backwards by 16.
      is_branch = 1'b1;
      funct3    = 3'b110;
      br_lt     = 1'b1;
      imm       = 32'hFFFF_FFF0;
      #1;
      tests++; if (br_un !== 1'b1 || taken !== 1'b1 || retire !== 1'b1) begin failed++; $display("FAIL bltu_comb: br_un=%b taken=%b retire=%b expected 1 1 1", br_un, taken, retire); end
      tick();
      tests++; if (pc !== 32'h0F0 || taken_cnt !== 16'd2) begin failed++; $display("FAIL bltu_pc: pc=%h cnt=%0d expected 000000f0 2", pc, taken_cnt); end
      // Condition table, imm=8 each row.
      exp_pc = 32'h0F0;
      for (int i = 0; i < 8; i++) begin
         is_branch = 1'b1;
         funct3    = t_f3[i];
         br_eq     = t_eq[i];
         br_lt     = t_lt[i];
         imm       = 32'd8;
         #1;
         tests++; if (taken !== t_tk[i] || br_un !== t_un[i]) begin failed++; $display("FAIL cond_row%0d: taken=%b br_un=%b expected %b %b", i, taken, br_un, t_tk[i], t_un[i]); end
         tick();
         exp_pc = t_tk[i] ? exp_pc + 32'd8 : exp_pc + 32'd4;
         tests++; if (pc !== exp_pc) begin failed++; $display("FAIL cond_pc%0d: got %h expected %h", i, pc, exp_pc); end
      end
      clear_inputs();
      tests++; if (pc !== 32'h11C || taken_cnt !== 16'd5) begin failed++; $display("FAIL cond_final: pc=%h cnt=%0d expected 0000011c 5", pc, taken_cnt); end
   endtask

   task automatic test_priority();
      // All three classes: JALR wins, (0x301+0xFF)=0x400.
      is_jalr   = 1'b1;
      is_jal    = 1'b1;
      is_branch = 1'b1;
      funct3    = 3'b000;
      br_eq     = 1'b0;
      rs1_data  = 32'h301;
      imm       = 32'hFF;
      tick();
      tests++; if (pc !== 32'h400 || taken_cnt !== 16'd6) begin failed++; $display("FAIL prio_jalr: pc=%h cnt=%0d expected 00000400 6", pc, taken_cnt); end
      // JAL beats a not-taken branch.
      clear_inputs();
      is_jal    = 1'b1;
      is_branch = 1'b1;
      funct3    = 3'b001;
      br_eq     = 1'b1;
      imm       = 32'h10;
      tick();
      tests++; if (pc !== 32'h410 || taken_cnt !== 16'd7) begin failed++; $display("FAIL prio_jal: pc=%h cnt=%0d expected 00000410 7", pc, taken_cnt); end
      // JALR clears bit 0 of an odd sum.
      clear_inputs();
      is_jalr  = 1'b1;
      rs1_data = 32'h500;
      imm      = 32'h1;
      #1;
      tests++; if (taken !== 1'b1) begin failed++; $display("FAIL jalr_bit0_taken: got %b expected 1", taken); end
      tick();
      clear_inputs();
      tests++; if (pc !== 32'h500 || taken_cnt !== 16'd8) begin failed++; $display("FAIL jalr_bit0: pc=%h cnt=%0d expected 00000500 8", pc, taken_cnt); end
   endtask

   task automatic test_wrap_pc();
      is_jal = 1'b1;
      imm    = 32'hFFFF_FAFC;
      tick();
      clear_inputs();
      tests++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin failed++; $display("FAIL pc_top: pc=%h pc_plus4=%h expected fffffffc 00000000", pc, pc_plus4); end
      tick();
      tests++; if (pc !== 32'h0 || taken_cnt !== 16'd9) begin failed++; $display("FAIL pc_wrap: pc=%h cnt=%0d expected 00000000 9", pc, taken_cnt); end
   endtask

   task automatic test_stall();
      imem_ready = 1'b0;
      is_branch  = 1'b1;
      funct3     = 3'b000;
      br_eq      = 1'b1;
      imm        = 32'h40;
      #1;
      tests++; if (retire !== 1'b0 || taken !== 1'b0 || fetch_req !== 1'b1) begin failed++; $display("FAIL stall_comb: retire=%b taken=%b fetch_req=%b expected 0 0 1", retire, taken, fetch_req); end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (pc !== 32'h0 || taken_cnt !== 16'd9) begin failed++; $display("FAIL stall_hold%0d: pc=%h cnt=%0d expected 00000000 9", i, pc, taken_cnt); end
      end
      imem_ready = 1'b1;
      #1;
      tests++; if (taken !== 1'b1) begin failed++; $display("FAIL stall_release: taken=%b expected 1", taken); end
      tick();
      clear_inputs();
      tests++; if (pc !== 32'h40 || taken_cnt !== 16'd10) begin failed++; $display("FAIL stall_redirect: pc=%h cnt=%0d expected 00000040 10", pc, taken_cnt); end
   endtask

   task automatic test_trap();
      is_jal = 1'b1;
      imm    = 32'h1C0;
      tick();
      clear_inputs();
      tests++; if (pc !== 32'h200 || taken_cnt !== 16'd11) begin failed++; $display("FAIL trap_setup: pc=%h cnt=%0d expected 00000200 11", pc, taken_cnt); end
      is_jalr  = 1'b1;
      rs1_data = 32'h1003;
      #1;
      tests++; if (retire !== 1'b0 || taken !== 1'b0) begin failed++; $display("FAIL trap_no_retire: retire=%b taken=%b expected 0 0", retire, taken); end
      tick();
      clear_inputs();
      tests++; if (trap !== 1'b1 || pc !== 32'h200 || fetch_req !== 1'b0 || taken_cnt !== 16'd11) begin failed++; $display("FAIL trap_enter: trap=%b pc=%h fetch_req=%b cnt=%0d expected 1 00000200 0 11", trap, pc, fetch_req, taken_cnt); end
      is_jal = 1'b1;
      imm    = 32'h8;
      repeat (3) tick();
      tests++; if (trap !== 1'b1 || pc !== 32'h200 || fetch_req !== 1'b0 || retire !== 1'b0 || taken_cnt !== 16'd11) begin failed++; $display("FAIL trap_sticky: trap=%b pc=%h fetch_req=%b retire=%b cnt=%0d expected 1 00000200 0 0 11", trap, pc, fetch_req, retire, taken_cnt); end
      apply_reset();
      tests++; if (trap !== 1'b0 || pc !== 32'h0 || fetch_req !== 1'b1) begin failed++; $display("FAIL trap_exit: trap=%b pc=%h fetch_req=%b expected 0 00000000 1", trap, pc, fetch_req); end
   endtask

   task automatic test_cnt_wrap();
      apply_reset();
      is_jal = 1'b1;
      imm    = 32'h0;
      repeat (65535) tick();
      tests++; if (taken_cnt !== 16'hFFFF || pc !== 32'h0) begin failed++; $display("FAIL cnt_full: cnt=%h pc=%h expected ffff 00000000", taken_cnt, pc); end
      tests++; if (taken !== 1'b1) begin failed++; $display("FAIL cnt_taken: got %b expected 1", taken); end
      tick();
      tests++; if (taken_cnt !== 16'h0) begin failed++; $display("FAIL cnt_wrap: got %h expected 0000", taken_cnt); end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      is_jal = 1'b1;
      imm    = 32'h80;
      tick();
      clear_inputs();
      imem_ready = 1'b0;
      tick();
      tests++; if (pc !== 32'h80 || taken_cnt !== 16'd1) begin failed++; $display("FAIL async_setup: pc=%h cnt=%0d expected 00000080 1", pc, taken_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (pc !== 32'h0 || taken_cnt !== 16'h0 || fetch_req !== 1'b0 || taken !== 1'b0 || retire !== 1'b0) begin failed++; $display("FAIL async_reset: pc=%h cnt=%0d fetch_req=%b taken=%b retire=%b expected 00000000 0 0 0 0", pc, taken_cnt, fetch_req, taken, retire); end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      tests      = 0;
      failed     = 0;
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      clear_inputs();
      test_reset();
      test_branch();
      test_priority();
      test_wrap_pc();
      test_stall();
      test_trap();
      test_cnt_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pc_branch_ctrl.md
PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: imem_ready  input  1  instruction memory accepts/returns current fetch this cycle.
REQ-005 Port: is_branch, is_jal, is_jalr  input  1 each  decoded control-flow class of current instruction.
REQ-006 Port: funct3  input  3  branch condition field.
REQ-007 Port: imm  input  32  sign-extended immediate.
REQ-008 Port: rs1_data  input  32  register operand for JALR base.
REQ-009 Port: br_eq, br_lt  input  1 each  results from the branch comparator.
REQ-010 Port: br_un  output  1  unsigned-compare select driven to the branch comparator.
REQ-011 Port: pc  output  32  current PC / fetch address.
REQ-012 Port: pc_plus4  output  32  pc + 4, link value for JAL/JALR.
REQ-013 Port: fetch_req  output  1  fetch request to instruction memory.
REQ-014 Port: retire  output  1  current instruction completes this cycle.
REQ-015 Port: taken  output  1  current retiring instruction redirects the PC.
REQ-016 Port: trap  output  1  misaligned-target trap, sticky.
REQ-017 Port: taken_cnt  output  16  count of retired redirects.

Function
REQ-018 br_un SHALL equal funct3[1], combinationally.
REQ-019 Branch condition: 000 br_eq; 001 !br_eq; 100/110 br_lt; 101/111 !br_lt; 010/011 not taken.
REQ-020 Target: branch and JAL: pc + imm; JALR: (rs1_data + imm) with bit 0 cleared; all 32-bit, wrap-around modulo 2^32, no overflow flag.
REQ-021 Priority when several class inputs are high: is_jalr > is_jal > is_branch.
REQ-022 redirect = is_jalr | is_jal | (is_branch & condition); next_pc = redirect ? target : pc + 4.
REQ-023 FSM states: BOOT, FETCH, TRAP.
REQ-024 BOOT: fetch_req=0, retire=0; unconditionally to FETCH next cycle.
REQ-025 FETCH: fetch_req=1; retire = imem_ready & !misaligned; PC loads next_pc on that edge (one-cycle latency); if imem_ready=0, PC, counter and state hold.
REQ-026 misaligned = redirect & (target[1:0] != 2'b00); when imem_ready & misaligned in FETCH: no retire, PC holds, go to TRAP.
REQ-027 TRAP: trap=1, fetch_req=0, retire=0, PC frozen; exits only by reset.
REQ-028 taken = retire & redirect.
REQ-029 taken_cnt SHALL increment by 1 on each taken cycle and wrap from 16'hFFFF to 0.
REQ-030 pc_plus4 = pc + 4 at all times, wrapping at 2^32.

Reset
REQ-031 rst_n low SHALL asynchronously force: state=BOOT, pc=RESET_VECTOR, taken_cnt=0, trap=0; fetch_req, retire, taken=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch; no partial PC or counter update.
REQ-033 Release of rst_n SHALL be followed by exactly one BOOT cycle before the first fetch_req.

Structure
REQ-034 Shared package SHALL hold the funct3 branch encodings, FSM state enum, and RESET_VECTOR default.
REQ-035 Condition/target computation SHALL be one sub-module, branch_target_gen (combinational); FSM, PC and counter remain in pc_branch_ctrl.

Verification
REQ-036 Reset then imem_ready=1, no class inputs: pc sequence 0,0(BOOT),0,4,8; taken_cnt=0.
REQ-037 pc=0x100, is_branch, funct3=110, br_lt=1, imm=-16: br_un=1, taken=1, next pc=0x0F0, taken_cnt+1.
REQ-038 pc=0x200, is_jalr, rs1_data=0x1003, imm=0: next pc=0x1002 -> trap=1, pc stays 0x200, fetch_req=0 until reset.
REQ-039 imem_ready held 0 for 3 cycles with taken branch pending: pc, taken_cnt unchanged; redirect on first ready cycle.
REQ-040 taken_cnt preloaded near 16'hFFFF via 65535 taken JALs to self (imm=0): next taken wraps taken_cnt to 0.
REQ-041 rst_n pulsed low mid-stall: pc=RESET_VECTOR immediately, asynchronously, before next clk edge.
